// File: rtl/bfloat16_wb_pkg.sv
// Shared definitions for the bfloat16 FMA Wishbone master and responder:
// sequencing states, register window offsets and the default base address.
package bfloat16_wb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_C,
      RD_OUT,
      GAP,
      RESP
   } fsm_state_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

   localparam logic [31:0] FMA_OFF_A   = 32'h0000_0000;
   localparam logic [31:0] FMA_OFF_B   = 32'h0000_0004;
   localparam logic [31:0] FMA_OFF_C   = 32'h0000_0008;
   localparam logic [31:0] FMA_OFF_OUT = 32'h0000_000C;

   localparam logic [3:0]  WB_SEL_WORD = 4'hF;

   // Transfer order A -> B -> C -> OUT; anything after the read answers.
   function automatic fsm_state_t next_xfer(input fsm_state_t cur);
      fsm_state_t nxt;
      case (cur)
         WR_A:    nxt = WR_B;
         WR_B:    nxt = WR_C;
         WR_C:    nxt = RD_OUT;
         default: nxt = RESP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/wb_master_xfer.sv
// Single Wishbone classic transfer: registers cyc/stb/adr/dat one cycle after start,
// holds them until ack or until TIMEOUT stalled cycles expire; ack wins a tie with the limit.
module wb_master_xfer
   import bfloat16_wb_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdata,
   input  logic        ack,
   output logic        done,
   output logic        timeout,
   output logic        cyc,
   output logic        stb,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_adr,
   output logic [31:0] bus_dat
);

   logic [7:0] wait_cnt;
   logic       at_limit;

   assign at_limit = (wait_cnt == (TIMEOUT - 8'd1));
   assign done     = cyc & stb & ack;
   assign timeout  = cyc & stb & ~ack & at_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc      <= 1'b0;
         stb      <= 1'b0;
         bus_we   <= 1'b0;
         bus_sel  <= '0;
         bus_adr  <= '0;
         bus_dat  <= '0;
         wait_cnt <= '0;
      end else if (start) begin
         cyc      <= 1'b1;
         stb      <= 1'b1;
         bus_we   <= we;
         bus_sel  <= WB_SEL_WORD;
         bus_adr  <= adr;
         bus_dat  <= wdata;
         wait_cnt <= '0;
      end else if (stb) begin
         if (done || timeout) begin
            // Return the bus to an all-zero idle so the responder sees no stale request.
            cyc      <= 1'b0;
            stb      <= 1'b0;
            bus_we   <= 1'b0;
            bus_sel  <= '0;
            bus_adr  <= '0;
            bus_dat  <= '0;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/bfloat16_fma_wb_master.sv
// Sequences A/B/C writes and the result read to the FMA responder, one idle GAP cycle between
// transfers; 4x(1+ack wait+1)+1 cycles per command, response held until rsp_ready.
module bfloat16_fma_wb_master
   import bfloat16_wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter logic [31:0] OFF_A     = FMA_OFF_A,
   parameter logic [31:0] OFF_B     = FMA_OFF_B,
   parameter logic [31:0] OFF_C     = FMA_OFF_C,
   parameter logic [31:0] OFF_OUT   = FMA_OFF_OUT,
   parameter logic [7:0]  TIMEOUT   = 8'd255
)
(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [15:0] cmd_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);

   fsm_state_t  state, next_state;
   fsm_state_t  ret_state, next_ret;
   logic [15:0] op_b, op_c;

   logic        xfer_start;
   logic        xfer_we;
   logic [31:0] xfer_adr;
   logic [31:0] xfer_wdata;
   logic        xfer_done;
   logic        xfer_timeout;

   wb_master_xfer #(
      .TIMEOUT (TIMEOUT)
   ) u_xfer (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .start   (xfer_start),
      .we      (xfer_we),
      .adr     (xfer_adr),
      .wdata   (xfer_wdata),
      .ack     (wbm_ack_i),
      .done    (xfer_done),
      .timeout (xfer_timeout),
      .cyc     (wbm_cyc_o),
      .stb     (wbm_stb_o),
      .bus_we  (wbm_we_o),
      .bus_sel (wbm_sel_o),
      .bus_adr (wbm_adr_o),
      .bus_dat (wbm_dat_o)
   );

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         ret_state <= IDLE;
         op_b      <= '0;
         op_c      <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= next_state;
         ret_state <= next_ret;
         // Operand A goes straight onto the bus at acceptance, so only B and C are held.
         if (state == IDLE && cmd_valid) begin
            op_b     <= cmd_b;
            op_c     <= cmd_c;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
         end
         if (state == RD_OUT && xfer_done) begin
            rsp_data <= wbm_dat_i;
         end
         if (xfer_timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_ret   = ret_state;
      xfer_start = 1'b0;
      xfer_we    = 1'b0;
      xfer_adr   = '0;
      xfer_wdata = '0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               next_state = WR_A;
               xfer_start = 1'b1;
               xfer_we    = 1'b1;
               xfer_adr   = BASE_ADDR + OFF_A;
               xfer_wdata = {16'h0000, cmd_a};
            end
         end
         WR_A, WR_B, WR_C, RD_OUT: begin
            if (xfer_done) begin
               next_state = GAP;
               next_ret   = next_xfer(state);
            end else if (xfer_timeout) begin
               next_state = RESP;
            end
         end
         GAP: begin
            next_state = ret_state;
            case (ret_state)
               WR_B: begin
                  xfer_start = 1'b1;
                  xfer_we    = 1'b1;
                  xfer_adr   = BASE_ADDR + OFF_B;
                  xfer_wdata = {16'h0000, op_b};
               end
               WR_C: begin
                  xfer_start = 1'b1;
                  xfer_we    = 1'b1;
                  xfer_adr   = BASE_ADDR + OFF_C;
                  xfer_wdata = {16'h0000, op_c};
               end
               RD_OUT: begin
                  xfer_start = 1'b1;
                  xfer_adr   = BASE_ADDR + OFF_OUT;
               end
               default: ;
            endcase
         end
         RESP: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bfloat16_fma_wb_master.sv
// Directed bench for bfloat16_fma_wb_master against a delayed-ack responder model (TIMEOUT=4).
module tb_bfloat16_fma_wb_master;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_a, cmd_b, cmd_c;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i;
   logic        busy;

   always #5 wb_clk_i = ~wb_clk_i;

   bfloat16_fma_wb_master #(
      .TIMEOUT (8'd4)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_c     (cmd_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .busy      (busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Responder: ack_dly stalled stb cycles precede ack; 0 means never ack.
   int          ack_dly   = 1;
   int          wcnt      = 0;
   logic        model_ack = 1'b0;
   logic        spur_ack  = 1'b0;
   logic [31:0] rd_val    = 32'h0;

   assign wbm_ack_i = model_ack | spur_ack;
   assign wbm_dat_i = (wbm_cyc_o && wbm_stb_o && !wbm_we_o) ? rd_val : 32'h0;

   always @(posedge wb_clk_i) begin
      if (wbm_cyc_o && wbm_stb_o && !model_ack) begin
         if (ack_dly > 0 && wcnt == ack_dly - 1) begin
            model_ack <= 1'b1;
            wcnt      <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         model_ack <= 1'b0;
         wcnt      <= 0;
      end
   end

   // Bus monitor: completed transfers, transfer start/end cycle indices, stability.
   logic [31:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic        log_we[$];
   int          xs_q[$];
   int          xe_q[$];
   int          cyc_idx  = 0;
   int          cyc_hi   = 0;
   int          unstable = 0;
   logic        cyc_prev = 1'b0;
   logic        hold     = 1'b0;
   logic [31:0] h_adr, h_dat;
   logic        h_we;

   always @(posedge wb_clk_i) begin
      cyc_idx++;
      if (wbm_cyc_o) cyc_hi++;
      if (wbm_cyc_o && !cyc_prev) xs_q.push_back(cyc_idx);
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         xe_q.push_back(cyc_idx);
         log_adr.push_back(wbm_adr_o);
         log_dat.push_back(wbm_dat_o);
         log_we.push_back(wbm_we_o);
      end
      if (hold && wbm_stb_o &&
          (wbm_adr_o !== h_adr || wbm_dat_o !== h_dat || wbm_we_o !== h_we || wbm_sel_o !== 4'hF))
         unstable++;
      hold     = wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
      h_adr    = wbm_adr_o;
      h_dat    = wbm_dat_o;
      h_we     = wbm_we_o;
      cyc_prev = wbm_cyc_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      cmd_a     = a;
      cmd_b     = b;
      cmd_c     = c;
      cmd_valid = 1'b1;
      @(posedge wb_clk_i);
      #1;
      cmd_valid = 1'b0;
   endtask

   // n = index of the cycle after acceptance in which rsp_valid is first seen.
   task automatic wait_rsp(input string tag, output int n);
      n = 1;
      while (!rsp_valid && n < 300) begin
         @(posedge wb_clk_i);
         #1;
         n++;
      end
      chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
   endtask

   task automatic take_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge wb_clk_i);
      #1;
      rsp_ready = 1'b0;
      chk({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic chk_xfer(input string tag, input int idx, input logic [31:0] adr,
                           input logic we, input logic [31:0] dat);
      chk({tag, "_adr"}, log_adr[idx], adr);
      chk({tag, "_we"}, 32'(log_we[idx]), 32'(we));
      chk({tag, "_dat"}, log_dat[idx], dat);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lb, sb, eb, cb, ub;
      bit found;

      wb_rst_i  = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_c     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(wbm_stb_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_adr", wbm_adr_o, 32'd0);
      chk("rst_sel", 32'(wbm_sel_o), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      wb_rst_i = 1'b0;
      @(posedge wb_clk_i);
      #1;

      // 1: single-cycle ack, 1.0*2.0+3.0 = 5.0
      ack_dly = 1;
      rd_val  = 32'h0000_40A0;
      lb = log_adr.size();
      send_cmd(16'h3F80, 16'h4000, 16'h4040);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_cmd_ready_low", 32'(cmd_ready), 32'd0);
      wait_rsp("t1", n);
      chk("t1_latency", 32'(n), 32'd13);
      chk("t1_rsp_data", rsp_data, 32'h0000_40A0);
      chk("t1_rsp_err", 32'(rsp_err), 32'd0);
      chk("t1_nxfer", 32'(log_adr.size() - lb), 32'd4);
      chk_xfer("t1_a", lb + 0, 32'h3000_0000, 1'b1, 32'h0000_3F80);
      chk_xfer("t1_b", lb + 1, 32'h3000_0004, 1'b1, 32'h0000_4000);
      chk_xfer("t1_c", lb + 2, 32'h3000_0008, 1'b1, 32'h0000_4040);
      chk_xfer("t1_out", lb + 3, 32'h3000_000C, 1'b0, 32'h0000_0000);
      take_rsp("t1");

      // 2: responder never acks -> timeout after 4 stb cycles in WR_A
      ack_dly = 0;
      lb = log_adr.size();
      sb = xs_q.size();
      cb = cyc_hi;
      send_cmd(16'h1111, 16'h2222, 16'h3333);
      wait_rsp("t2", n);
      chk("t2_latency", 32'(n), 32'd5);
      chk("t2_cyc_cycles", 32'(cyc_hi - cb), 32'd4);
      chk("t2_rsp_err", 32'(rsp_err), 32'd1);
      chk("t2_rsp_data", rsp_data, 32'd0);
      chk("t2_nstarts", 32'(xs_q.size() - sb), 32'd1);
      chk("t2_nacked", 32'(log_adr.size() - lb), 32'd0);
      chk("t2_cyc_low", 32'(wbm_cyc_o), 32'd0);
      take_rsp("t2");

      // 3: ack after 3 stall cycles; ack coincides with the timeout limit and must win
      ack_dly = 3;
      rd_val  = 32'h0000_4100;
      lb = log_adr.size();
      sb = xs_q.size();
      eb = xe_q.size();
      ub = unstable;
      send_cmd(16'h4040, 16'h4040, 16'hBF80);
      wait_rsp("t3", n);
      chk("t3_latency", 32'(n), 32'd21);
      chk("t3_rsp_data", rsp_data, 32'h0000_4100);
      chk("t3_rsp_err", 32'(rsp_err), 32'd0);
      chk("t3_nstarts", 32'(xs_q.size() - sb), 32'd4);
      chk("t3_nends", 32'(xe_q.size() - eb), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t3_dur%0d", i), 32'(xe_q[eb + i] - xs_q[sb + i] + 1), 32'd4);
      for (int i = 0; i < 3; i++)
         chk($sformatf("t3_gap%0d", i), 32'(xs_q[sb + i + 1] - xe_q[eb + i] - 1), 32'd1);
      chk("t3_bus_stable", 32'(unstable - ub), 32'd0);
      chk_xfer("t3_c", lb + 2, 32'h3000_0008, 1'b1, 32'h0000_BF80);
      take_rsp("t3");

      // 4: response back-pressure with a second command already waiting
      ack_dly = 1;
      rd_val  = 32'h0000_4110;
      send_cmd(16'h4000, 16'h4080, 16'h3F80);
      wait_rsp("t4", n);
      lb = log_adr.size();
      cmd_a     = 16'h3F80;
      cmd_b     = 16'h3F80;
      cmd_c     = 16'h0000;
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t4_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("t4_hold_data%0d", i), rsp_data, 32'h0000_4110);
         chk($sformatf("t4_hold_cmd_ready%0d", i), 32'(cmd_ready), 32'd0);
         @(posedge wb_clk_i);
         #1;
      end
      chk("t4_no_early_accept", 32'(log_adr.size() - lb), 32'd0);
      chk("t4_still_valid", 32'(rsp_valid), 32'd1);
      take_rsp("t4");
      rd_val = 32'h0000_3F80;
      @(posedge wb_clk_i);
      #1;
      cmd_valid = 1'b0;
      chk("t4_second_busy", 32'(busy), 32'd1);
      wait_rsp("t4b", n);
      chk("t4b_latency", 32'(n), 32'd13);
      chk("t4b_rsp_data", rsp_data, 32'h0000_3F80);
      chk_xfer("t4b_a", lb + 0, 32'h3000_0000, 1'b1, 32'h0000_3F80);
      take_rsp("t4b");

      // 5: reset while WR_C has stb asserted
      ack_dly = 1;
      rd_val  = 32'h0000_40A0;
      send_cmd(16'h3F80, 16'h4000, 16'h4040);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         if (wbm_stb_o && wbm_adr_o == 32'h3000_0008) found = 1'b1;
         else begin
            @(posedge wb_clk_i);
            #1;
         end
      end
      chk("t5_reached_wr_c", 32'(found), 32'd1);
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      chk("t5_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("t5_stb", 32'(wbm_stb_o), 32'd0);
      chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (5) @(posedge wb_clk_i);
      #1;
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t5_idle_bus", 32'(wbm_cyc_o), 32'd0);
      lb = log_adr.size();
      send_cmd(16'h3F80, 16'h4000, 16'h4040);
      wait_rsp("t5b", n);
      chk("t5b_latency", 32'(n), 32'd13);
      chk("t5b_rsp_data", rsp_data, 32'h0000_40A0);
      chk("t5b_rsp_err", 32'(rsp_err), 32'd0);
      chk("t5b_nxfer", 32'(log_adr.size() - lb), 32'd4);
      take_rsp("t5b");

      // 6: stray ack while idle
      spur_ack = 1'b1;
      @(posedge wb_clk_i);
      #1;
      spur_ack = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_cyc", 32'(wbm_cyc_o), 32'd0);
      @(posedge wb_clk_i);
      #1;
      chk("t6_rsp_valid_later", 32'(rsp_valid), 32'd0);
      chk("t6_busy_later", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
